port_event_queue: RTL and testbench

Input-side peripheral for the RAT MCU port bus. It captures key events from the keypad driver into a small FIFO and presents the oldest code and a status byte on the MCU input-port mux. It raises the MCU interrupt while events are pending and pops on an acknowledge written through the MCU output-port strobe. It sits in the wrapper between the keypad driver and the MCU, replacing the direct keypad-to-interrupt connection.

---
 rtl/port_event_queue.sv | 219 +++++++++++++++++++++
 tb/tb_port_event_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/port_event_queue.sv
// Key-event FIFO for the RAT MCU port bus: buffers keypad codes, serves head/status reads,
// pulses INTERRUPT while events are pending. Define PORT_EVENT_QUEUE_OVF_EN for the sticky OVERFLOW flag.
module port_event_queue #(
  parameter int         DEPTH          = 8,
  parameter int         DATA_W         = 4,
  parameter logic [7:0] DATA_PORT_ID   = 8'h80,
  parameter logic [7:0] STATUS_PORT_ID = 8'h83,
  parameter logic [7:0] ACK_PORT_ID    = 8'h84,
  parameter int         INT_PULSE_CYC  = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EVT_VALID,
  input  logic [DATA_W-1:0] EVT_DATA,
  input  logic [7:0]        PORT_ID,
  input  logic [7:0]        OUT_PORT,
  input  logic              IO_STRB,
  output logic [7:0]        IN_DATA,
  output logic              IN_HIT,
  output logic              INTERRUPT,
  output logic              OVERFLOW
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  logic              evt_r;
  logic              strb_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [7:0]        pulse_cnt_r;
  logic [7:0]        pulse_cnt_nxt_s;
  logic              pop_seen_r;
  logic              pop_seen_nxt_s;
  logic              int_r;
  logic              int_nxt_s;

  logic              push_req_s;
  logic              strb_rise_s;
  logic              ack_s;
  logic              pop_req_s;
  logic              empty_s;
  logic              full_s;
  logic              do_pop_s;
  logic              do_push_s;
  logic              ovf_set_s;
  logic [DATA_W-1:0] head_s;
  logic              unused_s;

  // Previous-cycle copies for rising-edge detection; reset high so a held level is not an edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      evt_r  <= 1'b1;
      strb_r <= 1'b1;
    end else begin
      evt_r  <= EVT_VALID;
      strb_r <= IO_STRB;
    end
  end

  assign push_req_s  = EVT_VALID & ~evt_r;
  assign strb_rise_s = IO_STRB & ~strb_r;
  assign ack_s       = strb_rise_s & (PORT_ID == ACK_PORT_ID);
  assign pop_req_s   = ack_s & OUT_PORT[0];
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign full_s      = (count_r == FULL_CNT);
  assign do_pop_s    = pop_req_s & ~empty_s;
  // A pop frees the slot first, so a push into a full queue still lands when paired with a pop
  assign do_push_s   = push_req_s & (~full_s | do_pop_s);
  assign ovf_set_s   = push_req_s & full_s & ~do_pop_s;
  assign head_s      = mem_r[rd_ptr_r];

  // FIFO storage, pointers and occupancy
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= EVT_DATA;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef PORT_EVENT_QUEUE_OVF_EN
  logic ovf_r;
  logic ovf_clr_s;

  assign ovf_clr_s = ack_s & OUT_PORT[1];

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign OVERFLOW = ovf_r;
  assign unused_s = ^{OUT_PORT[7:2]};
`else
  assign OVERFLOW = 1'b0;
  assign unused_s = ^{OUT_PORT[7:1], ovf_set_s};
`endif

  // Interrupt sequencing: fixed-length pulse, then wait for an acknowledging pop
  always_comb begin
    state_nxt_s     = state_r;
    pulse_cnt_nxt_s = pulse_cnt_r;
    pop_seen_nxt_s  = pop_seen_r;
    int_nxt_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nxt_s     = ST_PULSE;
          pulse_cnt_nxt_s = 8'(INT_PULSE_CYC);
          pop_seen_nxt_s  = 1'b0;
          int_nxt_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_r <= 8'd1) begin
          pulse_cnt_nxt_s = 8'd0;
          pop_seen_nxt_s  = 1'b0;
          if (pop_seen_r | do_pop_s | empty_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end else begin
          pulse_cnt_nxt_s = pulse_cnt_r - 8'd1;
          pop_seen_nxt_s  = pop_seen_r | do_pop_s;
          int_nxt_s       = 1'b1;
        end
      end
      ST_ARMED: begin
        if (do_pop_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        pulse_cnt_nxt_s = 8'd0;
        pop_seen_nxt_s  = 1'b0;
      end
    endcase
  end

  // Interrupt state and registered INTERRUPT output
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      pulse_cnt_r <= 8'd0;
      pop_seen_r  <= 1'b0;
      int_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pulse_cnt_r <= pulse_cnt_nxt_s;
      pop_seen_r  <= pop_seen_nxt_s;
      int_r       <= int_nxt_s;
    end
  end

  assign INTERRUPT = int_r;

  // Zero-latency read mux for the MCU input port
  always_comb begin
    IN_DATA = 8'h00;
    IN_HIT  = 1'b0;
    if (PORT_ID == DATA_PORT_ID) begin
      IN_HIT = 1'b1;
      if (empty_s) begin
        IN_DATA = 8'h00;
      end else begin
        IN_DATA = 8'(head_s);
      end
    end else if (PORT_ID == STATUS_PORT_ID) begin
      IN_HIT  = 1'b1;
      IN_DATA = {OVERFLOW, full_s, empty_s, 1'b0, 4'(count_r)};
    end else begin
      IN_DATA = 8'h00;
      IN_HIT  = 1'b0;
    end
  end

endmodule

// File: tb/tb_port_event_queue.sv
// Directed bench for port_event_queue with a queue-level reference model checked every cycle.
module tb_port_event_queue;

  localparam logic [7:0] P_DATA = 8'h80;
  localparam logic [7:0] P_STAT = 8'h83;
  localparam logic [7:0] P_ACK  = 8'h84;
  localparam int         PULSE  = 4;
  localparam int         QDEPTH = 8;

`ifdef PORT_EVENT_QUEUE_OVF_EN
  localparam logic [7:0] FULL_OVF_STATUS = 8'hC8;
`else
  localparam logic [7:0] FULL_OVF_STATUS = 8'h48;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       EVT_VALID = 1'b0;
  logic [3:0] EVT_DATA = 4'h0;
  logic [7:0] PORT_ID = 8'h83;
  logic [7:0] OUT_PORT = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] IN_DATA;
  logic       IN_HIT;
  logic       INTERRUPT;
  logic       OVERFLOW;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  port_event_queue dut (
    .CLK(CLK), .RESET_N(RESET_N), .EVT_VALID(EVT_VALID), .EVT_DATA(EVT_DATA),
    .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
    .IN_DATA(IN_DATA), .IN_HIT(IN_HIT), .INTERRUPT(INTERRUPT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Reference model: an unbounded event log (head/tail indices) plus the interrupt obligation
  logic [3:0] m_mem [256];
  int         m_head = 0;
  int         m_tail = 0;
  bit         m_ovf = 1'b0;
  bit         m_evt_prev = 1'b1;
  bit         m_strb_prev = 1'b1;
  int         m_int_left = 0;
  bit         m_wait = 1'b0;
  bit         m_acked = 1'b0;

  always @(posedge CLK or negedge RESET_N) begin : model
    automatic int len;
    automatic bit push;
    automatic bit ackw;
    automatic bit pop;
    automatic bit room;
    if (!RESET_N) begin
      m_head <= 0; m_tail <= 0; m_ovf <= 1'b0;
      m_evt_prev <= 1'b1; m_strb_prev <= 1'b1;
      m_int_left <= 0; m_wait <= 1'b0; m_acked <= 1'b0;
    end else begin
      len  = m_tail - m_head;
      push = EVT_VALID && !m_evt_prev;
      ackw = IO_STRB && !m_strb_prev && (PORT_ID == P_ACK);
      pop  = ackw && OUT_PORT[0] && (len > 0);
      room = (len < QDEPTH) || pop;
      m_evt_prev  <= EVT_VALID;
      m_strb_prev <= IO_STRB;
      if (pop) m_head <= m_head + 1;
      if (push && room) begin
        m_mem[m_tail % 256] <= EVT_DATA;
        m_tail <= m_tail + 1;
      end
`ifdef PORT_EVENT_QUEUE_OVF_EN
      if (push && !room) m_ovf <= 1'b1;
      else if (ackw && OUT_PORT[1]) m_ovf <= 1'b0;
`endif
      if (m_int_left > 0) begin
        m_int_left <= m_int_left - 1;
        if (m_int_left == 1) m_wait <= !(m_acked || pop || len == 0);
        else if (pop) m_acked <= 1'b1;
      end else if (m_wait) begin
        if (pop) m_wait <= 1'b0;
      end else if (len > 0) begin
        m_int_left <= PULSE;
        m_acked <= 1'b0;
      end
    end
  end

  function automatic logic [7:0] exp_status();
    int len;
    len = m_tail - m_head;
    return {m_ovf, len == QDEPTH, len == 0, 1'b0, 4'(len)};
  endfunction

  function automatic logic [7:0] exp_in_data(input logic [7:0] pid);
    if (pid == P_DATA) return (m_tail == m_head) ? 8'h00 : {4'h0, m_mem[m_head % 256]};
    if (pid == P_STAT) return exp_status();
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_in_data", IN_DATA, exp_in_data(PORT_ID));
      check("cyc_in_hit", {7'h0, IN_HIT}, {7'h0, (PORT_ID == P_DATA) || (PORT_ID == P_STAT)});
      check("cyc_interrupt", {7'h0, INTERRUPT}, {7'h0, m_int_left > 0});
      check("cyc_overflow", {7'h0, OVERFLOW}, {7'h0, m_ovf});
    end
  end

  int int_hi = 0;
  int int_rise = 0;
  logic int_prev = 1'b0;
  // Interrupt high-cycle and rising-edge tallies
  always @(negedge CLK) begin
    int_prev <= INTERRUPT;
    if (INTERRUPT) int_hi <= int_hi + 1;
    if (INTERRUPT && !int_prev) int_rise <= int_rise + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] code);
    EVT_DATA = code; EVT_VALID = 1'b1; tick(1);
    EVT_VALID = 1'b0; tick(1);
  endtask

  task automatic ack(input logic [7:0] val);
    PORT_ID = P_ACK; OUT_PORT = val; IO_STRB = 1'b1; tick(2);
    IO_STRB = 1'b0; OUT_PORT = 8'h00; PORT_ID = P_STAT; tick(1);
  endtask

  task automatic read(input string name, input logic [7:0] pid, input logic [7:0] exp);
    PORT_ID = pid; #1;
    check(name, IN_DATA, exp);
    PORT_ID = P_STAT;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; EVT_VALID = 1'b0; IO_STRB = 1'b0; OUT_PORT = 8'h00; PORT_ID = P_STAT;
    tick(2);
    RESET_N = 1'b1; tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi0, rise0;
    // Reset with EVT_VALID and IO_STRB held high across release
    #2 RESET_N = 1'b0; EVT_VALID = 1'b1; IO_STRB = 1'b1; chk_en = 1'b1;
    tick(2);
    RESET_N = 1'b1; tick(3);
    read("reset_status", P_STAT, 8'h20);
    check("reset_model_status", exp_status(), 8'h20);
    check("reset_int", {7'h0, INTERRUPT}, 8'h00);
    read("reset_data_empty", P_DATA, 8'h00);
    PORT_ID = 8'h81; #1;
    check("other_port_data", IN_DATA, 8'h00);
    check("other_port_hit", {7'h0, IN_HIT}, 8'h00);
    EVT_VALID = 1'b0; IO_STRB = 1'b0; PORT_ID = P_STAT;
    tick(2);

    // Single event: visible after edge N, interrupt from N+1 for PULSE cycles
    hi0 = int_hi; rise0 = int_rise;
    EVT_DATA = 4'h7; EVT_VALID = 1'b1; tick(1);
    EVT_VALID = 1'b0;
    read("single_data", P_DATA, 8'h07);
    read("single_status", P_STAT, 8'h01);
    check("single_model_status", exp_status(), 8'h01);
    check("single_int_n", {7'h0, INTERRUPT}, 8'h00);
    tick(1);
    check("single_int_n1", {7'h0, INTERRUPT}, 8'h01);
    tick(10);
    check("single_int_hi", 8'(int_hi - hi0), 8'd4);
    check("single_int_rise", 8'(int_rise - rise0), 8'd1);
    ack(8'h01);
    read("single_after_pop", P_STAT, 8'h20);

    // Overflow: nine pushes into eight entries, then clear
    do_reset();
    for (int i = 1; i <= 9; i++) push(4'(i));
    read("ovf_status", P_STAT, FULL_OVF_STATUS);
    read("ovf_head", P_DATA, 8'h01);
    tick(2);
    ack(8'h02);
    read("ovf_cleared", P_STAT, 8'h48);
    check("ovf_flag_cleared", {7'h0, OVERFLOW}, 8'h00);

    // Long strobe pops exactly once and triggers a second pulse
    do_reset();
    push(4'hA); push(4'hB); push(4'hC);
    tick(6);
    hi0 = int_hi; rise0 = int_rise;
    ack(8'h01);
    read("pop_status", P_STAT, 8'h02);
    read("pop_head", P_DATA, 8'h0B);
    tick(8);
    check("repulse_hi", 8'(int_hi - hi0), 8'd4);
    check("repulse_rise", 8'(int_rise - rise0), 8'd1);

    // Full queue with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 8; i++) push(4'(i));
    tick(6);
    EVT_DATA = 4'h9; EVT_VALID = 1'b1;
    PORT_ID = P_ACK; OUT_PORT = 8'h01; IO_STRB = 1'b1;
    tick(1);
    EVT_VALID = 1'b0; tick(1);
    IO_STRB = 1'b0; OUT_PORT = 8'h00; PORT_ID = P_STAT; tick(1);
    read("full_pp_status", P_STAT, 8'h48);
    read("full_pp_head", P_DATA, 8'h02);
    check("full_pp_ovf", {7'h0, OVERFLOW}, 8'h00);
    tick(6);
    for (int i = 0; i < 7; i++) begin
      ack(8'h01);
      tick(5);
    end
    read("full_pp_tail", P_DATA, 8'h09);
    read("full_pp_last", P_STAT, 8'h01);

    // Asynchronous reset in the middle of a pulse with five events queued
    do_reset();
    for (int i = 1; i <= 6; i++) push(4'(i));
    tick(6);
    ack(8'h01);
    read("midpulse_status", P_STAT, 8'h05);
    check("midpulse_int", {7'h0, INTERRUPT}, 8'h01);
    RESET_N = 1'b0; #1;
    check("async_int_low", {7'h0, INTERRUPT}, 8'h00);
    tick(2);
    RESET_N = 1'b1; tick(1);
    read("post_reset_status", P_STAT, 8'h20);
    tick(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
